pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_pkg.sv | 15 +
 rtl/pipe_skid_stage_if.sv | 26 ++
 rtl/sat_counter.sv | 33 +++
 rtl/pipe_skid_stage.sv | 105 ++++++++++
 tb/tb_pipe_skid_stage.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and default sizing for the pipe_skid_stage slice.
// Holds the skid-stage FSM state encoding used by the stage and its bench.
package pipe_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CH_W_DEF   = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream and downstream valid/ready/data handshake of one skid stage.
// master = the side driving the stage (producer and consumer), slave = the stage.
interface pipe_skid_stage_if #(
    parameter int NUM_CH = pipe_pkg::NUM_CH_DEF,
    parameter int CH_W   = pipe_pkg::CH_W_DEF
);
    localparam int W = NUM_CH * CH_W;

    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] out_data_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage: full throughput, registered handshake
// outputs, flush squash and a saturating downstream-stall statistic.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = CH_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stat_clr_i,
    pipe_skid_stage_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int W = NUM_CH * CH_W;

    state_e       state_d, state_q;
    logic [W-1:0] main_d, main_q;
    logic [W-1:0] skid_d, skid_q;
    logic         out_valid_d, out_valid_q;
    logic         in_ready_d, in_ready_q;
    logic         in_xfer, out_xfer;

    assign in_xfer  = bus.in_valid_i & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready_i;

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = bus.in_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    unique case ({in_xfer, out_xfer})
                        2'b11: main_d = bus.in_data_i;
                        2'b10: begin
                            skid_d  = bus.in_data_i;
                            state_d = TWO;
                        end
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake flags are flopped from the next state so no input reaches them combinationally.
    assign out_valid_d = (state_d != EMPTY);
    assign in_ready_d  = (state_d != TWO);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the payload registers are reset too, because out_data_o must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_data_o  = main_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stat_clr_i),
        .inc (out_valid_q & ~bus.out_ready_i),
        .cnt (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: directed scenarios plus random valid/ready,
// checked every cycle against a queue-based occupancy/order model.
module tb_pipe_skid_stage;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 8;
    localparam int CNT_W  = 4;
    localparam int W      = NUM_CH * CH_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             stat_clr;
    logic [CNT_W-1:0] stall_cnt;

    pipe_skid_stage_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    pipe_skid_stage #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .stat_clr_i  (stat_clr),
        .bus         (bus),
        .stall_cnt_o (stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the queue holds every accepted, not yet delivered entry.
    logic [W-1:0] exp_q[$];
    int           m_cnt    = 0;
    bit           zero_exp = 1'b1;
    bit           hold_v   = 1'b0;
    logic [W-1:0] hold_d   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the model, then advances the model across the next edge.
    always @(negedge clk) begin
        int  n;
        bit  in_x, out_x, stall;
        if (rst) begin
            exp_q.delete();
            m_cnt    = 0;
            zero_exp = 1'b1;
            hold_v   = 1'b0;
        end else begin
            n = exp_q.size();
            check("out_valid", bus.out_valid_o, 64'(n != 0));
            check("in_ready", bus.in_ready_o, 64'(n < 2));
            check("stall_cnt", stall_cnt, 64'(m_cnt));
            if (n != 0)
                check("out_data_order", bus.out_data_o, exp_q[0]);
            else if (zero_exp)
                check("out_data_zero", bus.out_data_o, 0);
            if (hold_v)
                check("held_stable", bus.out_data_o, hold_d);

            in_x  = bus.in_valid_i && (n < 2);
            out_x = (n != 0) && bus.out_ready_i;
            stall = (n != 0) && !bus.out_ready_i;
            hold_v = stall && !flush;
            hold_d = bus.out_data_o;
            if (stat_clr)
                m_cnt = 0;
            else if (stall && m_cnt < CNT_MAX)
                m_cnt++;
            if (out_x)
                void'(exp_q.pop_front());
            if (flush) begin
                exp_q.delete();
                zero_exp = 1'b1;
            end else if (in_x) begin
                exp_q.push_back(bus.in_data_i);
                zero_exp = 1'b0;
            end
        end
    end

    // Offers d, waits (bounded) for in_ready, returns just after the accepting edge.
    task automatic push(input logic [W-1:0] d, output int waits);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        waits = 0;
        while (!bus.in_ready_o && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        check("push_accept", bus.in_ready_o, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        bus.in_valid_i = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
    endtask

    initial begin
        int waits;
        rst = 1'b1;
        flush = 1'b0;
        stat_clr = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_in_ready", bus.in_ready_o, 1);
        check("rst_out_data", bus.out_data_o, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming: one cycle latency, one entry per cycle.
        bus.out_ready_i = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            push(W'(v), waits);
            check("stream_no_wait", waits, 0);
            check("stream_valid", bus.out_valid_o, 1);
            check("stream_data", bus.out_data_o, 64'(v));
        end
        idle(3);

        // Backpressure: A and B fill the stage, C waits upstream.
        clear_stats();
        bus.out_ready_i = 1'b0;
        push(W'(8'hA), waits);
        push(W'(8'hB), waits);
        check("bp_in_ready_low", bus.in_ready_o, 0);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = W'(8'hC);
        repeat (3) begin
            @(posedge clk); #1;
        end
        // Stalled edges: B's accept edge plus the three waiting edges.
        check("bp_stall_cnt", stall_cnt, 4);
        bus.out_ready_i = 1'b1;
        push(W'(8'hC), waits);
        check("bp_c_waited", waits, 1);
        idle(4);
        check("bp_stall_after", stall_cnt, 4);

        // Flush in TWO with an input offered in the same cycle.
        clear_stats();
        bus.out_ready_i = 1'b0;
        push(W'(8'hD), waits);
        push(W'(8'hE), waits);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = W'(8'hF);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_out_valid", bus.out_valid_o, 0);
        check("flush_out_data", bus.out_data_o, 0);
        check("flush_in_ready", bus.in_ready_o, 1);
        // The flush cycle is itself a stall cycle; the flush does not touch the counter.
        check("flush_stall_cnt", stall_cnt, 2);
        idle(2);

        // Flush coinciding with an output transfer: head delivered, skid entry dropped.
        push(W'(8'h61), waits);
        push(W'(8'h62), waits);
        bus.out_ready_i = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_xfer_valid", bus.out_valid_o, 0);
        idle(2);

        // Saturation and clear priority.
        clear_stats();
        bus.out_ready_i = 1'b0;
        push(W'(8'h77), waits);
        idle(20);
        check("sat_hold", stall_cnt, CNT_MAX);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("sat_clr", stall_cnt, 0);
        @(posedge clk); #1;
        check("sat_after_clr", stall_cnt, 1);
        bus.out_ready_i = 1'b1;
        idle(3);

        // Asynchronous reset while in TWO, then a fresh transfer from EMPTY.
        bus.out_ready_i = 1'b0;
        push(W'(8'h11), waits);
        push(W'(8'h22), waits);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = W'(8'h33);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", bus.out_valid_o, 0);
        check("async_rst_ready", bus.in_ready_o, 1);
        check("async_rst_cnt", stall_cnt, 0);
        check("async_rst_data", bus.out_data_o, 0);
        bus.in_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        push(W'(8'h5A), waits);
        check("post_rst_wait", waits, 0);
        check("post_rst_valid", bus.out_valid_o, 1);
        check("post_rst_data", bus.out_data_o, 64'h5A);
        idle(2);

        // Random valid/ready at 50%, occasional flush and stat clear.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid_i  = 1'($urandom_range(0, 1));
            bus.in_data_i   = W'($urandom);
            bus.out_ready_i = 1'($urandom_range(0, 1));
            flush           = ($urandom_range(0, 31) == 0);
            stat_clr        = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        stat_clr = 1'b0;
        bus.out_ready_i = 1'b1;
        idle(4);
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
